mem_dump_serializer: RTL and testbench
======================================

// Module: mem_dump_serializer
// PURPOSE
//  Debug-path stage directly downstream of the data memory's 1024-bit debug dump bus.
//  On a start request it snapshots the full dump (32 words x 32 bits) and streams it out
//  byte by byte over a valid/ready handshake toward the debug UART transmitter.
//  Optionally appends a one-byte XOR checksum. Runs only while the pipeline is halted.
// PARAMETERS
//  N_WORDS       32  number of memory words in the dump
//  WORD_W        32  bits per word; must be a multiple of 8
//  ADD_CHECKSUM  1   1: append XOR-of-all-bytes checksum byte after the last data byte
// PORTS
//  clk           in   1                      system clock, rising edge
//  i_reset       in   1                      asynchronous, active-high reset
//  i_start       in   1                      request a dump; sampled only in IDLE
//  i_mem_dump    in   N_WORDS*WORD_W (1024)  word 0 in the top bits [1023:992], word 31 in [31:0]
//  o_byte        out  8                      current byte; stable while o_valid && !i_ready
//  o_valid       out  1                      o_byte holds a byte to transmit
//  i_ready       in   1                      consumer accepts o_byte this cycle
//  o_busy        out  1                      high from the cycle after start acceptance until DONE exits
//  o_done        out  1                      one-cycle pulse after the final byte is accepted
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, o_valid=0, o_byte=0, o_busy=0, o_done=0,
//   byte counter=0, checksum=0, snapshot register=0.
//  Total data bytes NB = N_WORDS*WORD_W/8 (128 by default). Bytes go out word 0 first,
//   MSB byte of each word first: byte k = snapshot[TOP-8k -: 8].
//  States and transitions:
//   IDLE : i_start=1 -> capture i_mem_dump into snapshot, cnt=0, csum=0; go to SEND.
//          o_valid rises on the edge after the one that sampled i_start (1-cycle latency).
//   SEND : o_valid=1 and o_byte=top byte of snapshot. On valid&&ready: shift snapshot
//          left 8, csum ^= o_byte, cnt++. If cnt==NB-1 is accepted: go to CSUM if
//          ADD_CHECKSUM, else go to DONE.
//   CSUM : o_valid=1, o_byte=csum (XOR of all NB data bytes). On accept -> DONE.
//   DONE : o_valid=0, o_done=1 for exactly one cycle, o_busy=0 from the next cycle; -> IDLE.
//  Handshake: a transfer occurs only on a rising edge with o_valid&&i_ready. With i_ready
//   held high, one byte is transferred per cycle, no bubbles. o_byte never changes while
//   o_valid=1 and i_ready=0. o_valid never drops without a transfer, except on reset.
//  Snapshot isolation: changes on i_mem_dump after capture do not affect the stream.
//  i_start while not IDLE: ignored, not queued. i_start held high through DONE: a new dump
//   starts from IDLE on the cycle after DONE.
//  Counter width: clog2(NB+1) bits; cnt must not wrap within a dump.
//  Reset mid-stream: the transfer is aborted at once and the partial dump is discarded;
//   the next i_start restarts from byte 0.
// TESTING
//  1 Dump word n = 32'h0000_0100*n + n, i_ready=1, ADD_CHECKSUM=1 -> 129 bytes in 129
//    consecutive cycles: 00,00,00,00, 00,00,01,01, ...; the last byte equals the XOR of all
//    128 data bytes; o_done pulses once, 1 cycle after the last accept.
//  2 Word0=32'hDEADBEEF, rest 0, i_ready=0 for 5 cycles then 1 -> o_byte holds 8'hDE
//    stable with o_valid=1 during the stall; the stream then continues EF? no: DE,AD,BE,EF.
//  3 Random i_ready (50%), random dump, ADD_CHECKSUM=0 -> scoreboard gets exactly 128
//    bytes in order, and there is no checksum byte.
//  4 Change i_mem_dump to all-ones right after start is accepted -> the stream still
//    matches the captured snapshot.
//  5 Pulse i_start while in SEND at byte 40 -> it is ignored and the count stays at 128(+1).
//    Assert i_reset at byte 60 -> o_valid=0 immediately; a restart emits byte 0 first.

Source files
------------

// File: rtl/mem_dump_serializer.sv
// Snapshots the data-memory debug dump and streams it out MSB byte first over valid/ready,
// optionally followed by an XOR checksum byte.
module mem_dump_serializer #(
    parameter int N_WORDS      = 32,
    parameter int WORD_W       = 32,
    parameter bit ADD_CHECKSUM = 1'b1
) (
    input  logic                        clk,
    input  logic                        i_reset,
    input  logic                        i_start,
    input  logic [N_WORDS*WORD_W-1:0]   i_mem_dump,
    output logic [7:0]                  o_byte,
    output logic                        o_valid,
    input  logic                        i_ready,
    output logic                        o_busy,
    output logic                        o_done
);

    localparam int DUMP_W = N_WORDS * WORD_W;
    localparam int NB     = DUMP_W / 8;
    localparam int CNT_W  = $clog2(NB + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NB - 1);

    if (WORD_W % 8 != 0) begin : g_bad_word_w
        $error("WORD_W must be a multiple of 8");
    end

    typedef enum logic [1:0] {IDLE, SEND, CSUM, DONE} state_t;

    state_t              state;
    state_t              state_nxt;
    logic [DUMP_W-1:0]   snap;
    logic [CNT_W-1:0]    cnt;
    logic [7:0]          csum;
    logic [7:0]          top_byte;
    logic                accept;

    assign top_byte = snap[DUMP_W-1 -: 8];
    assign accept   = o_valid && i_ready;

    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (i_start) state_nxt = SEND;
            SEND: if (accept && cnt == LAST_CNT) state_nxt = ADD_CHECKSUM ? CSUM : DONE;
            CSUM: if (accept) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        o_valid = 1'b0;
        o_byte  = 8'h00;
        o_busy  = 1'b0;
        o_done  = 1'b0;
        case (state)
            SEND: begin
                o_valid = 1'b1;
                o_byte  = top_byte;
                o_busy  = 1'b1;
            end
            CSUM: begin
                o_valid = 1'b1;
                o_byte  = csum;
                o_busy  = 1'b1;
            end
            DONE: begin
                o_done = 1'b1;
                o_busy = 1'b1;
            end
            default: ;
        endcase
    end

    // Snapshot shifts left so the byte on offer is always the top one.
    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            snap <= '0;
            cnt  <= '0;
            csum <= 8'h00;
        end else begin
            if (state == IDLE && i_start) begin
                snap <= i_mem_dump;
                cnt  <= '0;
                csum <= 8'h00;
            end else if (state == SEND && i_ready) begin
                snap <= {snap[DUMP_W-9:0], 8'h00};
                csum <= csum ^ top_byte;
                cnt  <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_dump_serializer.sv
// Directed bench: two serializers (with and without checksum) share the same stimulus.
module tb_mem_dump_serializer;

    logic          clk = 1'b0;
    logic          i_reset = 1'b1;
    logic          i_start = 1'b0;
    logic [1023:0] i_mem_dump = '0;
    logic          i_ready = 1'b0;
    logic [7:0]    byte_a, byte_b;
    logic          valid_a, valid_b, busy_a, busy_b, done_a, done_b;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] q_a[$];
    logic [7:0] q_b[$];

    always #5 clk = ~clk;

    mem_dump_serializer #(.N_WORDS(32), .WORD_W(32), .ADD_CHECKSUM(1'b1)) u_dut_a (
        .clk(clk), .i_reset(i_reset), .i_start(i_start), .i_mem_dump(i_mem_dump),
        .o_byte(byte_a), .o_valid(valid_a), .i_ready(i_ready), .o_busy(busy_a), .o_done(done_a)
    );

    mem_dump_serializer #(.N_WORDS(32), .WORD_W(32), .ADD_CHECKSUM(1'b0)) u_dut_b (
        .clk(clk), .i_reset(i_reset), .i_start(i_start), .i_mem_dump(i_mem_dump),
        .o_byte(byte_b), .o_valid(valid_b), .i_ready(i_ready), .o_busy(busy_b), .o_done(done_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] byte_of(input logic [1023:0] d, input int k);
        return d[1023 - 8*k -: 8];
    endfunction

    // Called at a falling edge; returns at the falling edge after start was sampled.
    task automatic do_start(input logic [1023:0] d);
        check("idle_valid_a", valid_a, 0);
        check("idle_busy_a", busy_a, 0);
        i_start    = 1'b1;
        i_mem_dump = d;
        @(negedge clk);
        i_start = 1'b0;
        check("start_valid_a", valid_a, 1);
        check("start_busy_a", busy_a, 1);
        check("start_valid_b", valid_b, 1);
    endtask

    // Collect accepted bytes from both DUTs until both signal done or the budget runs out.
    task automatic collect(input int budget, input bit rnd, input int start_at, output int cyc);
        bit da = 0, db = 0, pulsed = 0;
        int la = -1, lb = -1, dca = -1, dcb = -1;
        q_a.delete();
        q_b.delete();
        cyc = 0;
        while (!(da && db) && cyc < budget) begin
            i_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (start_at >= 0 && q_a.size() == start_at && !pulsed) begin
                i_start = 1'b1;
                pulsed  = 1;
            end else begin
                i_start = 1'b0;
            end
            #1;
            if (valid_a && i_ready && !da) begin q_a.push_back(byte_a); la = cyc; end
            if (valid_b && i_ready && !db) begin q_b.push_back(byte_b); lb = cyc; end
            @(negedge clk);
            cyc++;
            if (done_a && !da) begin da = 1; dca = cyc; end
            if (done_b && !db) begin db = 1; dcb = cyc; end
        end
        i_start = 1'b0;
        i_ready = 1'b1;
        check("done_a_seen", da, 1);
        check("done_b_seen", db, 1);
        check("done_a_latency", dca, la + 1);
        check("done_b_latency", dcb, lb + 1);
        @(negedge clk);
        check("done_a_pulse", done_a, 0);
        check("busy_a_after_done", busy_a, 0);
        check("busy_b_after_done", busy_b, 0);
        check("valid_a_after_done", valid_a, 0);
    endtask

    task automatic verify(input string tag, input logic [1023:0] d);
        logic [7:0] cs = 8'h00;
        check({tag, "_count_a"}, q_a.size(), 129);
        check({tag, "_count_b"}, q_b.size(), 128);
        for (int k = 0; k < 128; k++) begin
            cs ^= byte_of(d, k);
            if (k < q_a.size()) check($sformatf("%s_a_byte%0d", tag, k), q_a[k], byte_of(d, k));
            if (k < q_b.size()) check($sformatf("%s_b_byte%0d", tag, k), q_b[k], byte_of(d, k));
        end
        if (q_a.size() > 128) check({tag, "_checksum"}, q_a[128], cs);
    endtask

    initial begin
        logic [1023:0] d;
        int cyc;
        int acc;

        // Reset state
        @(negedge clk);
        check("rst_valid", valid_a, 0);
        check("rst_byte", byte_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        @(negedge clk);
        i_reset = 1'b0;
        @(negedge clk);
        check("idle_done_b", done_b, 0);

        // Test 1: word n = 0x101*n style pattern, ready always high
        for (int n = 0; n < 32; n++) d[1023 - 32*n -: 32] = 32'h0000_0100 * n + n;
        i_ready = 1'b1;
        do_start(d);
        collect(400, 1'b0, -1, cyc);
        check("t1_cycles", cyc, 129);
        check("t1_byte6", q_a[6], 8'h01);
        check("t1_byte7", q_a[7], 8'h01);
        check("t1_byte11", q_a[11], 8'h02);
        check("t1_checksum_hand", q_a[128], 8'h00);
        verify("t1", d);

        // Test 2: stall on the first byte
        d = '0;
        d[1023:992] = 32'hDEAD_BEEF;
        i_ready = 1'b0;
        do_start(d);
        for (int c = 0; c < 5; c++) begin
            check("t2_stall_valid", valid_a, 1);
            check("t2_stall_byte", byte_a, 8'hDE);
            check("t2_stall_busy", busy_a, 1);
            @(negedge clk);
        end
        collect(400, 1'b0, -1, cyc);
        check("t2_byte1", q_a[1], 8'hAD);
        check("t2_byte2", q_a[2], 8'hBE);
        check("t2_byte3", q_a[3], 8'hEF);
        check("t2_checksum_hand", q_a[128], 8'h22);
        verify("t2", d);

        // Test 3: random dump with random ready
        for (int n = 0; n < 32; n++) d[1023 - 32*n -: 32] = $urandom();
        i_ready = 1'b1;
        do_start(d);
        collect(2000, 1'b1, -1, cyc);
        verify("t3", d);

        // Test 4: dump bus changes right after capture
        for (int n = 0; n < 32; n++) d[1023 - 32*n -: 32] = $urandom();
        do_start(d);
        i_mem_dump = '1;
        collect(400, 1'b0, -1, cyc);
        verify("t4", d);

        // Test 5a: start pulse at byte 40 is ignored
        for (int n = 0; n < 32; n++) d[1023 - 32*n -: 32] = $urandom();
        do_start(d);
        collect(400, 1'b0, 40, cyc);
        check("t5_cycles", cyc, 129);
        verify("t5", d);

        // Test 5b: reset at byte 60, then restart
        do_start(d);
        acc = 0;
        for (int c = 0; c < 200 && acc < 60; c++) begin
            #1;
            if (valid_a && i_ready) acc++;
            @(negedge clk);
        end
        check("t5_accepted_60", acc, 60);
        check("t5_valid_before_rst", valid_a, 1);
        i_reset = 1'b1;
        #1;
        check("t5_rst_valid_a", valid_a, 0);
        check("t5_rst_valid_b", valid_b, 0);
        check("t5_rst_busy", busy_a, 0);
        check("t5_rst_byte", byte_a, 0);
        @(negedge clk);
        i_reset = 1'b0;
        @(negedge clk);
        for (int n = 0; n < 32; n++) d[1023 - 32*n -: 32] = 32'h0102_0304 + n;
        do_start(d);
        check("t5_restart_byte0", byte_a, 8'h01);
        collect(400, 1'b0, -1, cyc);
        verify("t5r", d);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
